// File: rtl/ul_rx_controller_pkg.sv
// Shared frame geometry, link constants and state encoding for the uplink receive path.
package ul_rx_controller_pkg;

  localparam int SERIAL_DATA_WIDTH   = 8;
  localparam int SERIAL_DATA_DEPTH   = 8;
  localparam int ENC0_PAR_DATA_WIDTH = 8;
  localparam int ENC0_PAR_DATA_DEPTH = 7;
  localparam int ENC1_PAR_DATA_WIDTH = 6;
  localparam int ENC1_PAR_DATA_DEPTH = 4;
  localparam int DL_PREAMBLE_COUNT   = 8;
  localparam int UL_SYNC_STAGES      = 2;

  localparam int COL_W = $clog2(SERIAL_DATA_WIDTH);
  localparam int ROW_W = $clog2(SERIAL_DATA_DEPTH);
  localparam int PRE_W = $clog2(DL_PREAMBLE_COUNT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_DONE     = 2'd3
  } ul_state_t;

  function automatic logic [COL_W-1:0] last_col(input logic enc);
    return enc ? COL_W'(ENC1_PAR_DATA_WIDTH - 1) : COL_W'(ENC0_PAR_DATA_WIDTH - 1);
  endfunction

  function automatic logic [ROW_W-1:0] last_row(input logic enc);
    return enc ? ROW_W'(ENC1_PAR_DATA_DEPTH - 1) : ROW_W'(ENC0_PAR_DATA_DEPTH - 1);
  endfunction

endpackage

// File: rtl/ul_rx_controller_bit_sampler.sv
// Bit-phase counter: phase runs 0..div, strobe fires mid-bit at phase == div>>1.
// On start the current cycle is treated as phase 0 so the first bit can be sampled immediately.
module ul_bit_sampler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 strobe
);

  logic [DIV_WIDTH-1:0] phase_q;
  logic [DIV_WIDTH-1:0] phase_cur;

  assign phase_cur = start ? '0 : phase_q;
  assign strobe    = (start | run) && (phase_cur == (div >> 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (start | run) begin
      phase_q <= (phase_cur == div) ? '0 : phase_cur + DIV_WIDTH'(1);
    end else begin
      phase_q <= '0;
    end
  end

endmodule

// File: rtl/ul_rx_controller.sv
// Uplink receive controller: preamble check, bit recovery and row/column frame reassembly.
// Build option UL_RX_SYNC_EN inserts a 2-flop synchronizer on ul_in and ul_en.
module ul_rx_controller
  import ul_rx_controller_pkg::*;
#(
  parameter int SERIAL_DIV_WIDTH = 8
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              ul_in,
  input  logic                                              ul_en,
  input  logic                                              enc_used,
  input  logic [SERIAL_DIV_WIDTH-1:0]                       ser_clk_div,
  output logic [SERIAL_DATA_DEPTH-1:0][SERIAL_DATA_WIDTH-1:0] rx_data,
  output logic                                              rx_valid,
  output logic                                              rx_enc_used,
  output logic                                              rx_busy,
  output logic                                              preamble_err,
  output logic                                              frame_err
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DL_PREAMBLE_COUNT - 1);

  logic ul_in_s, ul_en_s, ul_en_d, rise;

`ifdef UL_RX_SYNC_EN
  logic [UL_SYNC_STAGES-1:0] in_sync_p0, en_sync_p0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sync_p0 <= '0;
      en_sync_p0 <= '0;
    end else begin
      in_sync_p0 <= {in_sync_p0[UL_SYNC_STAGES-2:0], ul_in};
      en_sync_p0 <= {en_sync_p0[UL_SYNC_STAGES-2:0], ul_en};
    end
  end
  assign ul_in_s = in_sync_p0[UL_SYNC_STAGES-1];
  assign ul_en_s = en_sync_p0[UL_SYNC_STAGES-1];
`else
  assign ul_in_s = ul_in;
  assign ul_en_s = ul_en;
`endif

  ul_state_t                   state_q, state_d;
  logic                        enc_q;
  logic [SERIAL_DIV_WIDTH-1:0] div_q, div_cur;
  logic [PRE_W-1:0]            pre_idx_q, pre_idx_cur;
  logic [ROW_W-1:0]            row_q;
  logic [COL_W-1:0]            col_q;
  logic                        start, abort, pre_fail, last_bit, pre_active, run, strobe;

  assign rise     = ul_en_s & ~ul_en_d;
  assign run      = (state_q == S_PREAMBLE) || (state_q == S_PAYLOAD);
  assign div_cur  = start ? ser_clk_div : div_q;
  assign rx_valid = (state_q == S_DONE);

  ul_bit_sampler #(.DIV_WIDTH(SERIAL_DIV_WIDTH)) u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .run    (run),
    .div    (div_cur),
    .strobe (strobe)
  );

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    abort       = 1'b0;
    pre_fail    = 1'b0;
    last_bit    = 1'b0;
    pre_active  = 1'b0;
    pre_idx_cur = pre_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          start       = 1'b1;
          pre_active  = 1'b1;
          pre_idx_cur = '0;
          state_d     = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        pre_active = 1'b1;
        if (!ul_en_s) abort = 1'b1;
      end
      S_PAYLOAD: begin
        if (!ul_en_s) begin
          abort = 1'b1;
        end else if (strobe && (col_q == '0) && (row_q == last_row(enc_q))) begin
          last_bit = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A dropped link outranks every sample decision in the same cycle.
    if (abort) begin
      state_d = S_IDLE;
    end else if (pre_active && strobe) begin
      if (ul_in_s != ~pre_idx_cur[0]) begin
        pre_fail = 1'b1;
        state_d  = S_IDLE;
      end else if (pre_idx_cur == PRE_LAST) begin
        state_d = S_PAYLOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ul_en_d <= 1'b0;
    end else begin
      state_q <= state_d;
      ul_en_d <= ul_en_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q        <= 1'b0;
      div_q        <= '0;
      pre_idx_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rx_data      <= '0;
      rx_enc_used  <= 1'b0;
      rx_busy      <= 1'b0;
      preamble_err <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      preamble_err <= pre_fail;
      frame_err    <= abort;
      rx_busy      <= (state_d == S_PREAMBLE) || (state_d == S_PAYLOAD);
      if (start) begin
        enc_q     <= enc_used;
        div_q     <= ser_clk_div;
        pre_idx_q <= '0;
        row_q     <= '0;
        col_q     <= last_col(enc_used);
        rx_data   <= '0;
      end
      if (pre_active && strobe && !abort) pre_idx_q <= pre_idx_cur + PRE_W'(1);
      if ((state_q == S_PAYLOAD) && strobe && !abort) begin
        rx_data[row_q][col_q] <= ul_in_s;
        if (col_q == '0) begin
          col_q <= last_col(enc_q);
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q - COL_W'(1);
        end
      end
      if (last_bit) rx_enc_used <= enc_q;
    end
  end

endmodule

// File: doc/ul_rx_controller.md
# ul_rx_controller

Receive-side link controller that consumes the serial stream produced by the downlink controller (`dl_out`/`dl_en`). It checks the training preamble, recovers payload bits at the programmed serial rate, and reassembles them into the packed row/column frame the packet scrambler produced. The recovered frame goes to the downstream packet descrambler / CRC / decoder path. It sits at the far end of the serial link, mirroring the `dl_controller` on the transmit side.

## Interface
- `SERIAL_DIV_WIDTH`, 8, width of the serial clock divider; must match the transmitter.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ul_in` in 1: serial data, driven from the transmitter's `dl_out`.
- `ul_en` in 1: link-active qualifier, driven from the transmitter's `dl_en`.
- `enc_used` in 1: encoder selection (0 = ENC0, 1 = ENC1); sampled at frame start.
- `ser_clk_div` in SERIAL_DIV_WIDTH: clock cycles per bit minus 1; sampled at frame start.
- `rx_data` out [SERIAL_DATA_DEPTH-1:0][SERIAL_DATA_WIDTH-1:0]: recovered frame, held until the next frame start.
- `rx_valid` out 1: one-cycle pulse when a complete frame is in `rx_data`.
- `rx_enc_used` out 1: the `enc_used` value latched for the frame in `rx_data`.
- `rx_busy` out 1: high from the rising edge of `ul_en` until the frame completes or aborts.
- `preamble_err` out 1: one-cycle pulse on a preamble mismatch.
- `frame_err` out 1: one-cycle pulse when `ul_en` drops before the payload is complete.

## Operation
- **Reset values.** All outputs are 0 and `rx_data` is all zeros; the state is S_IDLE.
- **States.** S_IDLE, S_PREAMBLE, S_PAYLOAD, S_DONE.
- **S_IDLE → S_PREAMBLE.** Taken on the rising edge of `ul_en` (previous value 0, current value 1).
  - Latch `enc_used` and `ser_clk_div`.
  - Clear the bit-phase counter and the bit index.
  - Clear `rx_data`.
- **Bit timing.**
  - Bit period is div+1 cycles. The phase counter runs 0..div and wraps to 0.
  - Sample strobe fires at phase == div>>1.
  - With div = 0, every cycle is a sample.
- **S_PREAMBLE.**
  - Expects DL_PREAMBLE_COUNT bits, alternating and starting with 1 (1,0,1,0,…).
  - A mismatch on any sampled bit pulses `preamble_err` and returns to S_IDLE.
  - After the last matching preamble bit, the next cycle is phase 0 of payload bit 0.
- **Payload geometry.**
  - Width W = ENC0/ENC1_PAR_DATA_WIDTH and depth D = ENC0/ENC1_PAR_DATA_DEPTH, selected by the latched `enc_used`.
  - Total W·D bits.
- **S_PAYLOAD.**
  - Row 0 arrives first. Within a row, bit W-1 arrives first.
  - Each sample writes `rx_data[row][col]`.
  - col decrements from W-1 to 0, then row increments and col reloads to W-1.
  - Bits above W-1 and rows above D-1 remain 0.
- **Completion.** When the sample for row D-1, col 0 is taken, go to S_DONE.
- **S_DONE.** For one cycle: pulse `rx_valid`, drive `rx_enc_used`, then return to S_IDLE.
- **`ul_en` low while in S_PREAMBLE or S_PAYLOAD.** Pulse `frame_err`, go to S_IDLE, no `rx_valid`. Partial `rx_data` stays visible but is not valid.
- **`ul_en` still high after completion.** No new frame starts until `ul_en` has gone low and then risen again.
- **Reset mid-frame.** Immediate return to reset values; no error pulse.
- **Simultaneous events.**
  - A `ul_en` falling edge on the same cycle as the final sample: `frame_err` wins, no `rx_valid`.
  - `enc_used` or `ser_clk_div` changing mid-frame: ignored.

## Timing
- Preamble bit k (zero-based) is sampled (div>>1) + k·(div+1) cycles after the cycle in which the `ul_en` rise is seen.
- `rx_valid` asserts 1 cycle after the final sample. Total latency from the `ul_en` rise is (DL_PREAMBLE_COUNT + W·D − 1)·(div+1) + (div>>1) + 1 cycles (plus 2 cycles with the synchronizer).
- `rx_busy` falls in the same cycle that `rx_valid` or an error pulses.
- `rx_data` is stable from `rx_valid` until the next frame-start cycle.

## Configuration
- Macro: `UL_RX_SYNC_EN`.
- Defined: `ul_in` and `ul_en` each pass through a 2-flop synchronizer (reset to 0) before any logic. All latencies grow by 2 cycles.
- Undefined: the inputs are used directly. The link is assumed synchronous to `clk`, as in the on-chip loopback.

## Structure
- `fec_pkg` additions:
  - `ul_state_t` (enum logic [1:0]).
  - `UL_SYNC_STAGES = 2`.
  - Reuse SERIAL_DATA_WIDTH/DEPTH, ENC0/1_PAR_DATA_WIDTH/DEPTH and DL_PREAMBLE_COUNT.
- Sub-module `ul_bit_sampler`:
  - Phase counter with a `start`/clear input and a `strobe` output, parameterized by DIV_WIDTH.
  - Shared in shape with the training and serializer dividers.
- The top module holds the FSM, the index counters and `rx_data`.

## Test plan
- **ENC0 frame.** Drive a `dl_controller` with div = 3 and `enc_used` = 0, and a known 56-bit `data_in`. → `rx_valid` pulses once, `rx_data` equals the scrambler's `par_out`, and `rx_enc_used` = 0.
- **ENC1 frame.** Same as above but div = 0 and `enc_used` = 1. → The frame matches, and unused rows/cols are 0.
- **Corrupted preamble.** Flip preamble bit 3 with div = 2. → `preamble_err` pulses at that sample, there is no `rx_valid`, and `rx_busy` is 0 in the next cycle.
- **Dropped link.** Drop `ul_en` midway through payload row 1. → `frame_err` pulses one cycle later, and the next good frame is received correctly.
- **Reset mid-payload.** Assert `rst_n` low mid-payload. → All outputs are 0 at once, and the following frame decodes correctly.
- **Synchronizer build.** With `UL_RX_SYNC_EN` defined, repeat the ENC0 frame test. → `rx_valid` arrives exactly 2 cycles later than in the undefined build.
